// File: rtl/dec_op_fz_if.sv
// Bus bundle for the Fz instruction decoder: fetched word in, decoded fields out.
interface dec_op_fz_if;
    logic [63:0] istrWord;
    logic [5:0]  idRegN;
    logic [5:0]  idRegM;
    logic [5:0]  idRegO;
    logic [32:0] idImm;
    logic [7:0]  idUCmd;
    logic [7:0]  idUIxt;

    // Fetch side drives the word and observes the decode.
    modport master (
        output istrWord,
        input  idRegN, idRegM, idRegO, idImm, idUCmd, idUIxt
    );

    // Decoder side consumes the word and drives the decode.
    modport slave (
        input  istrWord,
        output idRegN, idRegM, idRegO, idImm, idUCmd, idUIxt
    );
endinterface

// File: rtl/dec_op_fz.sv
// dec_op_fz: decoder for 32-bit F-block (Fz) instruction words, one word per cycle,
// all outputs registered (1-cycle latency).
// Optional feature: define DECOPFZ_FPU_EN to decode block 0x9 as FPU 3R ops;
// otherwise block 0x9 decodes as an invalid op.
module dec_op_fz (
    input  logic         clock,
    input  logic         reset,
    dec_op_fz_if.slave   bus
);
    localparam int unsigned REG_W  = 6;
    localparam int unsigned IMM_W  = 33;
    localparam int unsigned UOP_W  = 8;

    localparam logic [REG_W-1:0] ZZR      = 6'h3F;
    localparam logic [5:0]       UC_NOP   = 6'h00;
    localparam logic [5:0]       UC_LD    = 6'h01;
    localparam logic [5:0]       UC_ST    = 6'h02;
    localparam logic [5:0]       UC_ALU   = 6'h03;
    localparam logic [5:0]       UC_MOVI  = 6'h04;
`ifdef DECOPFZ_FPU_EN
    localparam logic [5:0]       UC_FPU   = 6'h05;
`endif
    localparam logic [5:0]       UC_INVOP = 6'h3F;

    typedef struct packed {
        logic [REG_W-1:0] reg_n;
        logic [REG_W-1:0] reg_m;
        logic [REG_W-1:0] reg_o;
        logic [IMM_W-1:0] imm;
        logic [UOP_W-1:0] ucmd;
        logic [UOP_W-1:0] uixt;
    } dec_t;

    logic [31:0]      word;
    logic [3:0]       blk;
    logic [3:0]       fn;
    logic [8:0]       imm9;
    logic [REG_W-1:0] fld_n;
    logic [REG_W-1:0] fld_m;
    logic [REG_W-1:0] fld_o;
    logic [IMM_W-1:0] imm9_sx;
    dec_t             dec;
    logic             unused_bits;

    // Field extraction; bits [63:32] and [15:12] carry no meaning here.
    always_comb begin
        word    = bus.istrWord[31:0];
        blk     = word[11:8];
        fn      = word[19:16];
        imm9    = word[28:20];
        fld_n   = {1'b0, word[31], word[7:4]};
        fld_m   = {1'b0, word[30], word[3:0]};
        fld_o   = {1'b0, word[29], word[23:20]};
        imm9_sx = {{(IMM_W-9){imm9[8]}}, imm9};
    end

    assign unused_bits = ^{bus.istrWord[63:32], bus.istrWord[15:12]};

    // Block decode; anything not explicitly valid falls through as INVOP.
    always_comb begin
        dec.reg_n = ZZR;
        dec.reg_m = ZZR;
        dec.reg_o = ZZR;
        dec.imm   = '0;
        dec.ucmd  = {2'b00, UC_INVOP};
        dec.uixt  = '0;
        case (blk)
            4'h0: begin
                if (!fn[3]) begin
                    dec.reg_n = fld_n;
                    dec.reg_m = fld_m;
                    dec.reg_o = fld_o;
                    dec.ucmd  = {2'b00, UC_ALU};
                    dec.uixt  = {4'h0, fn};
                end
            end
            4'h1: begin
                dec.reg_n = fld_n;
                dec.reg_m = fld_m;
                dec.imm   = imm9_sx;
                dec.ucmd  = {2'b00, (fn[3] ? UC_ST : UC_LD)};
                dec.uixt  = {5'b0_0000, fn[2:0]};
            end
            4'h2: begin
                if (!fn[3]) begin
                    dec.reg_n = fld_n;
                    dec.reg_m = fld_m;
                    dec.imm   = imm9_sx;
                    dec.ucmd  = {2'b00, UC_ALU};
                    dec.uixt  = {4'h8, fn};
                end
            end
            4'h8: begin
                // word[3] picks zero- vs sign-extension of the 16-bit literal.
                dec.reg_n = {2'b00, word[7:4]};
                dec.imm   = word[3] ? {17'h0_0000, word[31:16]}
                                    : {{17{word[31]}}, word[31:16]};
                dec.ucmd  = {2'b00, UC_MOVI};
                dec.uixt  = '0;
            end
`ifdef DECOPFZ_FPU_EN
            4'h9: begin
                if (!fn[3]) begin
                    dec.reg_n = fld_n;
                    dec.reg_m = fld_m;
                    dec.reg_o = fld_o;
                    dec.ucmd  = {2'b00, UC_FPU};
                    dec.uixt  = {4'h0, fn};
                end
            end
`endif
            default: begin
                dec.ucmd = {2'b00, UC_INVOP};
            end
        endcase
    end

    // Output registers; reset presents a NOP with no registers selected.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.idRegN <= ZZR;
            bus.idRegM <= ZZR;
            bus.idRegO <= ZZR;
            bus.idImm  <= '0;
            bus.idUCmd <= {2'b00, UC_NOP};
            bus.idUIxt <= '0;
        end else begin
            bus.idRegN <= dec.reg_n;
            bus.idRegM <= dec.reg_m;
            bus.idRegO <= dec.reg_o;
            bus.idImm  <= dec.imm;
            bus.idUCmd <= dec.ucmd;
            bus.idUIxt <= dec.uixt;
        end
    end
endmodule

// File: tb/tb_dec_op_fz.sv
// Directed testbench for dec_op_fz; honours DECOPFZ_FPU_EN the same way as the RTL.
module tb_dec_op_fz;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    dec_op_fz_if bus ();

    dec_op_fz dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {RegN, RegM, RegO, Imm, UCmd, UIxt} packed for a single comparison.
    function automatic logic [66:0] pack_exp(input logic [5:0] n, input logic [5:0] m,
                                             input logic [5:0] o, input logic [32:0] imm,
                                             input logic [7:0] ucmd, input logic [7:0] uixt);
        return {n, m, o, imm, ucmd, uixt};
    endfunction

    function automatic logic [66:0] observed();
        return {bus.idRegN, bus.idRegM, bus.idRegO, bus.idImm, bus.idUCmd, bus.idUIxt};
    endfunction

    // Drive a word between edges, then step past the next rising edge.
    task automatic apply(input logic [31:0] w);
        @(negedge clock);
        bus.istrWord = {$urandom(), w};
        @(posedge clock);
        #1;
    endtask

    logic [66:0] inv_exp;
    logic [66:0] exp_v;
    logic [66:0] got_v;

    task automatic test_reset();
        reset = 1'b1;
        bus.istrWord = {$urandom(), $urandom()};
        repeat (2) @(posedge clock);
        #1;
        checks++;
        got_v = observed();
        exp_v = pack_exp(6'h3F, 6'h3F, 6'h3F, 33'h0, 8'h00, 8'h00);
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", got_v, exp_v);
        end
        @(negedge clock);
        reset = 1'b0;
        apply(32'h0001_F012);
        checks++;
        got_v = observed();
        exp_v = pack_exp(6'h01, 6'h02, 6'h00, 33'h0, 8'h03, 8'h01);
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL first_after_reset got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_load_store();
        // B=1, F=2 (F[3]=0 -> LD), imm9=0x1FF -> -1
        apply(32'h1FF2_F134);
        checks++;
        got_v = observed();
        exp_v = pack_exp(6'h03, 6'h04, 6'h3F, 33'h1_FFFF_FFFF, 8'h01, 8'h02);
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL ld_neg_disp got=%h exp=%h", got_v, exp_v);
        end
        // B=1, F=8 -> ST size 0, M uses bit30, imm9=0x001
        apply(32'h4018_F134);
        checks++;
        got_v = observed();
        exp_v = pack_exp(6'h03, 6'h14, 6'h3F, 33'h0_0000_0001, 8'h02, 8'h00);
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL st_pos_disp got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_imm_alu();
        // B=2, F=1, N uses bit31, imm9=0x0AB
        apply(32'h8AB1_F221);
        checks++;
        got_v = observed();
        exp_v = pack_exp(6'h12, 6'h01, 6'h3F, 33'h0_0000_00AB, 8'h03, 8'h81);
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL imm_alu got=%h exp=%h", got_v, exp_v);
        end
        // B=2, F=9 invalid
        apply(32'h0009_F221);
        checks++;
        got_v = observed();
        if (got_v !== inv_exp) begin
            errors++;
            $display("FAIL imm_alu_inv got=%h exp=%h", got_v, inv_exp);
        end
    endtask

    task automatic test_movi();
        apply(32'h8000_F850);
        checks++;
        got_v = observed();
        exp_v = pack_exp(6'h05, 6'h3F, 6'h3F, 33'h1_FFFF_8000, 8'h04, 8'h00);
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL movi_sext got=%h exp=%h", got_v, exp_v);
        end
        apply(32'h8000_F858);
        checks++;
        got_v = observed();
        exp_v = pack_exp(6'h05, 6'h3F, 6'h3F, 33'h0_0000_8000, 8'h04, 8'h00);
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL movi_zext got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_upper_bits();
        logic [31:0] words [3];
        words[0] = 32'h2035_E0A7;
        words[1] = 32'h2035_F0A7;
        words[2] = 32'h2035_D0A7;
        // B=0, F=5 (SHL), N=0x0A, M=0x07, O={0,1,3}=0x13
        exp_v = pack_exp(6'h0A, 6'h07, 6'h13, 33'h0, 8'h03, 8'h05);
        for (int i = 0; i < 3; i++) begin
            apply(words[i]);
            checks++;
            got_v = observed();
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL upper_bits_%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_invalid();
        apply(32'h000A_F012);
        checks++;
        got_v = observed();
        if (got_v !== inv_exp) begin
            errors++;
            $display("FAIL inv_3r_f10 got=%h exp=%h", got_v, inv_exp);
        end
        apply(32'h0001_F512);
        checks++;
        got_v = observed();
        if (got_v !== inv_exp) begin
            errors++;
            $display("FAIL inv_blk5 got=%h exp=%h", got_v, inv_exp);
        end
    endtask

    task automatic test_fpu();
        apply(32'h0002_F912);
`ifdef DECOPFZ_FPU_EN
        exp_v = pack_exp(6'h01, 6'h02, 6'h00, 33'h0, 8'h05, 8'h02);
`else
        exp_v = inv_exp;
`endif
        checks++;
        got_v = observed();
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL fpu_blk9 got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        // Consecutive words each show up exactly one edge later.
        apply(32'h0000_F012);
        checks++;
        got_v = observed();
        exp_v = pack_exp(6'h01, 6'h02, 6'h00, 33'h0, 8'h03, 8'h00);
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL b2b_add got=%h exp=%h", got_v, exp_v);
        end
        apply(32'h0007_F0FF);
        checks++;
        got_v = observed();
        exp_v = pack_exp(6'h0F, 6'h0F, 6'h00, 33'h0, 8'h03, 8'h07);
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL b2b_sar got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        got_v = observed();
        exp_v = pack_exp(6'h3F, 6'h3F, 6'h3F, 33'h0, 8'h00, 8'h00);
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", got_v, exp_v);
        end
        @(negedge clock);
        reset = 1'b0;
        apply(32'h0004_F034);
        checks++;
        got_v = observed();
        exp_v = pack_exp(6'h03, 6'h04, 6'h00, 33'h0, 8'h03, 8'h04);
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL after_async_reset got=%h exp=%h", got_v, exp_v);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        bus.istrWord = '0;
        inv_exp = pack_exp(6'h3F, 6'h3F, 6'h3F, 33'h0, 8'h3F, 8'h00);
        test_reset();
        test_load_store();
        test_imm_alu();
        test_movi();
        test_upper_bits();
        test_invalid();
        test_fpu();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
